// File: rtl/mfp_timer_pkg.sv
// Shared encodings for the MFP-style timer: mode decode, control bit positions
// and the prescale divisor table.
package mfp_timer_pkg;

  localparam int unsigned CTRL_PS_LSB  = 0;
  localparam int unsigned CTRL_PS_MSB  = 2;
  localparam int unsigned CTRL_MODE    = 3;
  localparam int unsigned CTRL_ONESHOT = 4;
  localparam int unsigned CTRL_CLR_TO  = 5;

  localparam logic [3:0] MODE_STOPPED = 4'b0000;
  localparam logic [3:0] MODE_EVENT   = 4'b1000;

  typedef enum logic [1:0] {
    ModeStop,
    ModeDelay,
    ModeEvent,
    ModePulse
  } mode_e;

  function automatic mode_e decode_mode(input logic [3:0] ctrl);
    if (ctrl == MODE_STOPPED)  return ModeStop;
    else if (ctrl == MODE_EVENT) return ModeEvent;
    else if (ctrl[3])          return ModePulse;
    else                       return ModeDelay;
  endfunction

  // Code 0 has no divisor; the prescaler is held clear whenever it is selected.
  function automatic logic [7:0] prescale_div(input logic [2:0] code);
    case (code)
      3'd1:    return 8'd4;
      3'd2:    return 8'd10;
      3'd3:    return 8'd16;
      3'd4:    return 8'd50;
      3'd5:    return 8'd64;
      3'd6:    return 8'd100;
      3'd7:    return 8'd200;
      default: return 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/mfp_timer_n_prescaler.sv
// XCLK_EN divider: one-cycle TICK on the strobe at which the count reaches divisor-1.
module mfp_prescaler
  import mfp_timer_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       XCLK_EN,
  input  logic [2:0] CODE,
  input  logic       CLEAR,
  output logic       TICK
);

  logic [7:0] r_cnt;
  logic [7:0] w_div;
  logic       w_last;

  assign w_div  = prescale_div(CODE);
  assign w_last = (r_cnt == (w_div - 8'd1));
  assign TICK   = XCLK_EN && !CLEAR && (CODE != 3'd0) && w_last;

  always_ff @(posedge CLK) begin
    if (RST || CLEAR) begin
      r_cnt <= 8'd0;
    end else if (XCLK_EN) begin
      r_cnt <= w_last ? 8'd0 : r_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/mfp_timer_n.sv
// MFP-style timer channel: delay, event-count and pulse-width modes with a
// reloadable down-counter, toggle output and timeout pulse.
module mfp_timer_n
  import mfp_timer_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter bit          TI_ACTIVE_HIGH = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLK_EN,
  input  logic             XCLK_EN,
  input  logic             DAT_WE,
  input  logic [WIDTH-1:0] DAT_I,
  output logic [WIDTH-1:0] DAT_O,
  input  logic             CTRL_WE,
  input  logic [5:0]       CTRL_I,
  output logic [4:0]       CTRL_O,
  input  logic             T_I,
  output logic             T_O,
  output logic             T_O_PULSE,
  output logic             PULSE_MODE,
  output logic             RUNNING,
  output logic [WIDTH-1:0] SET_DATA_OUT
);

  logic [WIDTH-1:0] r_data, r_counter, r_dat_o;
  logic [4:0]       r_ctrl;
  logic             r_ti_s1, r_ti_s2, r_ti_prev;
  logic             r_count_en, r_t_o, r_t_o_pulse, r_os_stop;

  mode_e w_mode;
  logic  w_stopped, w_ti_pol, w_presc_clr, w_presc_tick, w_tick, w_timeout, w_stop_wr;

  assign w_mode      = decode_mode(r_ctrl[3:0]);
  assign w_stopped   = (w_mode == ModeStop);
  assign w_ti_pol    = TI_ACTIVE_HIGH ? T_I : ~T_I;
  assign w_presc_clr = w_stopped || (w_mode == ModeEvent) || CTRL_WE;
  assign w_stop_wr   = CTRL_WE && (CTRL_I[3:0] == MODE_STOPPED);
  assign w_timeout   = r_count_en && !w_stopped && (r_counter == WIDTH'(1));

  mfp_prescaler u_prescaler (
    .CLK     (CLK),
    .RST     (RST),
    .XCLK_EN (XCLK_EN),
    .CODE    (r_ctrl[CTRL_PS_MSB:CTRL_PS_LSB]),
    .CLEAR   (w_presc_clr),
    .TICK    (w_presc_tick)
  );

  always_comb begin
    w_tick = 1'b0;
    case (w_mode)
      ModeDelay: w_tick = w_presc_tick;
      ModeEvent: w_tick = r_ti_s2 && !r_ti_prev;
      ModePulse: w_tick = w_presc_tick && r_ti_s2;
      default:   w_tick = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_data      <= '0;
      r_counter   <= '0;
      r_dat_o     <= '0;
      r_ctrl      <= '0;
      r_ti_s1     <= 1'b0;
      r_ti_s2     <= 1'b0;
      r_ti_prev   <= 1'b0;
      r_count_en  <= 1'b0;
      r_t_o       <= 1'b0;
      r_t_o_pulse <= 1'b0;
      r_os_stop   <= 1'b0;
    end else begin
      r_ti_s1     <= w_ti_pol;
      r_ti_s2     <= r_ti_s1;
      r_ti_prev   <= r_ti_s2;
      r_count_en  <= w_tick && !w_stop_wr;
      r_t_o_pulse <= w_timeout;
      r_os_stop   <= w_timeout && r_ctrl[CTRL_ONESHOT];

      if (DAT_WE) r_data <= DAT_I;

      // A data write landing on a timeout reloads from the new value.
      if (DAT_WE && (w_stopped || w_timeout)) r_counter <= DAT_I;
      else if (w_timeout)                     r_counter <= r_data;
      else if (r_count_en && !w_stopped)      r_counter <= r_counter - WIDTH'(1);

      if (CTRL_WE)        r_ctrl      <= CTRL_I[4:0];
      else if (r_os_stop) r_ctrl[3:0] <= MODE_STOPPED;

      if (CTRL_WE && CTRL_I[CTRL_CLR_TO]) r_t_o <= 1'b0;
      else if (w_timeout)                 r_t_o <= ~r_t_o;

      if (CLK_EN) r_dat_o <= r_counter;
    end
  end

  assign DAT_O        = r_dat_o;
  assign CTRL_O       = r_ctrl;
  assign T_O          = r_t_o;
  assign T_O_PULSE    = r_t_o_pulse;
  assign PULSE_MODE   = (w_mode == ModePulse);
  assign RUNNING      = !w_stopped;
  assign SET_DATA_OUT = r_data;

endmodule

// File: tb/tb_mfp_timer_n.sv
// Directed bench for mfp_timer_n: an 8-bit channel for most modes and a 12-bit
// channel for the data=0 full-period case.
module tb_mfp_timer_n;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en = 1'b1;
  logic        xclk_en = 1'b0;
  logic        dat_we = 1'b0;
  logic [7:0]  dat_i = '0;
  logic [7:0]  dat_o;
  logic        ctrl_we = 1'b0;
  logic [5:0]  ctrl_i = '0;
  logic [4:0]  ctrl_o;
  logic        t_i = 1'b0;
  logic        t_o, t_o_pulse, pulse_mode, running;
  logic [7:0]  set_data_out;

  logic        w_dat_we = 1'b0;
  logic [11:0] w_dat_i = '0;
  logic [11:0] w_dat_o;
  logic        w_ctrl_we = 1'b0;
  logic [5:0]  w_ctrl_i = '0;
  logic [4:0]  w_ctrl_o;
  logic        w_t_i = 1'b0;
  logic        w_t_o, w_t_o_pulse, w_pulse_mode, w_running;
  logic [11:0] w_set_data_out;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int w_pulses = 0;

  always #5 clk = ~clk;

  mfp_timer_n #(.WIDTH(8), .TI_ACTIVE_HIGH(1'b1)) dut (
    .CLK(clk), .RST(rst), .CLK_EN(clk_en), .XCLK_EN(xclk_en),
    .DAT_WE(dat_we), .DAT_I(dat_i), .DAT_O(dat_o),
    .CTRL_WE(ctrl_we), .CTRL_I(ctrl_i), .CTRL_O(ctrl_o),
    .T_I(t_i), .T_O(t_o), .T_O_PULSE(t_o_pulse), .PULSE_MODE(pulse_mode),
    .RUNNING(running), .SET_DATA_OUT(set_data_out)
  );

  mfp_timer_n #(.WIDTH(12), .TI_ACTIVE_HIGH(1'b1)) dut_w (
    .CLK(clk), .RST(rst), .CLK_EN(clk_en), .XCLK_EN(1'b0),
    .DAT_WE(w_dat_we), .DAT_I(w_dat_i), .DAT_O(w_dat_o),
    .CTRL_WE(w_ctrl_we), .CTRL_I(w_ctrl_i), .CTRL_O(w_ctrl_o),
    .T_I(w_t_i), .T_O(w_t_o), .T_O_PULSE(w_t_o_pulse), .PULSE_MODE(w_pulse_mode),
    .RUNNING(w_running), .SET_DATA_OUT(w_set_data_out)
  );

  always @(negedge clk) begin
    if (t_o_pulse) pulses <= pulses + 1;
    if (w_t_o_pulse) w_pulses <= w_pulses + 1;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_data(input logic [7:0] v);
    dat_we = 1'b1; dat_i = v;
    step(1);
    dat_we = 1'b0;
  endtask

  task automatic write_ctrl(input logic [5:0] v);
    ctrl_we = 1'b1; ctrl_i = v;
    step(1);
    ctrl_we = 1'b0;
  endtask

  task automatic ti_edge();
    t_i = 1'b1;
    step(3);
    t_i = 1'b0;
    step(4);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(1);
    checks++; if (dat_o !== 8'h00) begin errors++; $display("FAIL reset_dat_o: got %0h want 0", dat_o); end
    checks++; if (ctrl_o !== 5'h00) begin errors++; $display("FAIL reset_ctrl_o: got %0h want 0", ctrl_o); end
    checks++; if (t_o !== 1'b0 || t_o_pulse !== 1'b0) begin errors++; $display("FAIL reset_t_o: got %b/%b want 0/0", t_o, t_o_pulse); end
    checks++; if (running !== 1'b0 || pulse_mode !== 1'b0) begin errors++; $display("FAIL reset_mode: got %b/%b want 0/0", running, pulse_mode); end
    checks++; if (set_data_out !== 8'h00 || w_dat_o !== 12'h000) begin errors++; $display("FAIL reset_data: got %0h/%0h want 0/0", set_data_out, w_dat_o); end
  endtask

  task automatic test_delay();
    int np = 0;
    int at[3];
    write_data(8'd3);
    write_ctrl(6'h01);
    xclk_en = 1'b1;
    for (int c = 0; c < 200 && np < 3; c++) begin
      step(1);
      if (t_o_pulse) begin
        at[np] = c;
        np++;
        checks++; if (t_o !== np[0]) begin errors++; $display("FAIL delay_t_o_%0d: got %b want %b", np, t_o, np[0]); end
      end
    end
    xclk_en = 1'b0;
    checks++;
    if (np != 3) begin errors++; $display("FAIL delay_pulses: got %0d want 3", np); end
    else begin
      checks++; if (at[1] - at[0] != 12) begin errors++; $display("FAIL delay_period1: got %0d want 12", at[1] - at[0]); end
      checks++; if (at[2] - at[1] != 12) begin errors++; $display("FAIL delay_period2: got %0d want 12", at[2] - at[1]); end
    end
    write_ctrl(6'h20);
    step(1);
    checks++; if (t_o !== 1'b0 || running !== 1'b0) begin errors++; $display("FAIL delay_stop: got t_o=%b run=%b want 0/0", t_o, running); end
  endtask

  task automatic test_event();
    logic [7:0] exp_seq [4] = '{8'd1, 8'd2, 8'd1, 8'd2};
    int p0;
    write_data(8'd2);
    write_ctrl(6'h08);
    step(1);
    checks++; if (dat_o !== 8'd2) begin errors++; $display("FAIL event_init: got %0d want 2", dat_o); end
    p0 = pulses;
    for (int i = 0; i < 4; i++) begin
      ti_edge();
      checks++; if (dat_o !== exp_seq[i]) begin errors++; $display("FAIL event_count_%0d: got %0d want %0d", i, dat_o, exp_seq[i]); end
    end
    checks++; if (pulses - p0 != 2) begin errors++; $display("FAIL event_timeouts: got %0d want 2", pulses - p0); end
    write_ctrl(6'h20);
  endtask

  task automatic test_pulse_gate();
    int p0;
    write_data(8'd7);
    write_ctrl(6'h09);
    p0 = pulses;
    t_i = 1'b0;
    xclk_en = 1'b1;
    step(100);
    checks++; if (dat_o !== 8'd7) begin errors++; $display("FAIL pulse_gated_count: got %0d want 7", dat_o); end
    checks++; if (pulse_mode !== 1'b1 || running !== 1'b1) begin errors++; $display("FAIL pulse_mode: got %b/%b want 1/1", pulse_mode, running); end
    checks++; if (pulses != p0) begin errors++; $display("FAIL pulse_gated_timeouts: got %0d want 0", pulses - p0); end
    t_i = 1'b1;
    step(45);
    checks++; if (pulses - p0 != 1) begin errors++; $display("FAIL pulse_open_timeouts: got %0d want 1", pulses - p0); end
    xclk_en = 1'b0;
    t_i = 1'b0;
    write_ctrl(6'h20);
    step(4);
    checks++; if (pulse_mode !== 1'b0) begin errors++; $display("FAIL pulse_mode_off: got %b want 0", pulse_mode); end
  endtask

  task automatic test_one_shot();
    int p0;
    write_data(8'd5);
    p0 = pulses;
    write_ctrl(6'h11);
    xclk_en = 1'b1;
    step(60);
    xclk_en = 1'b0;
    checks++; if (pulses - p0 != 1) begin errors++; $display("FAIL oneshot_timeouts: got %0d want 1", pulses - p0); end
    checks++; if (ctrl_o !== 5'h10) begin errors++; $display("FAIL oneshot_ctrl: got %0h want 10", ctrl_o); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL oneshot_running: got %b want 0", running); end
    checks++; if (dat_o !== 8'd5) begin errors++; $display("FAIL oneshot_count: got %0d want 5", dat_o); end
  endtask

  task automatic test_back_to_back();
    write_ctrl(6'h20);
    write_data(8'd2);
    write_ctrl(6'h08);
    ti_edge();
    checks++; if (dat_o !== 8'd1) begin errors++; $display("FAIL b2b_pre: got %0d want 1", dat_o); end
    // Timeout cycle is the third cycle after raising T_I.
    t_i = 1'b1;
    step(3);
    dat_we = 1'b1; dat_i = 8'h20;
    step(1);
    dat_we = 1'b0;
    checks++; if (t_o_pulse !== 1'b1 || t_o !== 1'b1) begin errors++; $display("FAIL b2b_dat_timeout: got %b/%b want 1/1", t_o_pulse, t_o); end
    step(1);
    checks++; if (dat_o !== 8'h20) begin errors++; $display("FAIL b2b_dat_reload: got %0h want 20", dat_o); end
    t_i = 1'b0;
    step(4);
    write_ctrl(6'h00);
    write_data(8'd1);
    write_ctrl(6'h08);
    checks++; if (t_o !== 1'b1) begin errors++; $display("FAIL b2b_t_o_held: got %b want 1", t_o); end
    t_i = 1'b1;
    step(3);
    ctrl_we = 1'b1; ctrl_i = 6'h28;
    step(1);
    ctrl_we = 1'b0;
    checks++; if (t_o_pulse !== 1'b1) begin errors++; $display("FAIL b2b_ctrl_timeout: got %b want 1", t_o_pulse); end
    checks++; if (t_o !== 1'b0) begin errors++; $display("FAIL b2b_clear_wins: got %b want 0", t_o); end
    step(1);
    checks++; if (dat_o !== 8'd1) begin errors++; $display("FAIL b2b_ctrl_reload: got %0d want 1", dat_o); end
    t_i = 1'b0;
    step(4);
  endtask

  task automatic test_reset_mid();
    int p0;
    p0 = pulses;
    t_i = 1'b1;
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    t_i = 1'b0;
    step(5);
    checks++; if (pulses != p0) begin errors++; $display("FAIL rstmid_pulse: got %0d want 0", pulses - p0); end
    checks++; if (t_o !== 1'b0 || ctrl_o !== 5'h00) begin errors++; $display("FAIL rstmid_state: got %b/%0h want 0/0", t_o, ctrl_o); end
    checks++; if (dat_o !== 8'h00 || set_data_out !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %0h/%0h want 0/0", dat_o, set_data_out); end
  endtask

  task automatic test_wide();
    int p0;
    w_dat_we = 1'b1; w_dat_i = 12'h000;
    step(1);
    w_dat_we = 1'b0;
    w_ctrl_we = 1'b1; w_ctrl_i = 6'h08;
    step(1);
    w_ctrl_we = 1'b0;
    p0 = w_pulses;
    for (int i = 0; i < 4095; i++) begin
      w_t_i = 1'b1; step(2);
      w_t_i = 1'b0; step(2);
    end
    step(4);
    checks++; if (w_dat_o !== 12'd1) begin errors++; $display("FAIL wide_pre: got %0h want 1", w_dat_o); end
    checks++; if (w_pulses != p0) begin errors++; $display("FAIL wide_early: got %0d want 0", w_pulses - p0); end
    w_t_i = 1'b1; step(2);
    w_t_i = 1'b0; step(6);
    checks++; if (w_pulses - p0 != 1) begin errors++; $display("FAIL wide_timeout: got %0d want 1", w_pulses - p0); end
    checks++; if (w_dat_o !== 12'd0) begin errors++; $display("FAIL wide_reload: got %0h want 0", w_dat_o); end
  endtask

  initial begin
    test_reset();
    test_delay();
    test_event();
    test_pulse_gate();
    test_one_shot();
    test_back_to_back();
    test_reset_mid();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
